// File: rtl/delay_line_ctrl_pkg.sv
// Shared types for the delay-line controller: FSM states and request arbitration.
// DELAY_LINE_CLEAR_EN adds a CLEAR state that zeroes a buffer region on reconfiguration.
package delay_line_ctrl_pkg;

`ifdef DELAY_LINE_CLEAR_EN
    typedef enum logic [2:0] {StIdle, StAddr, StMem, StResp, StCfg, StClear} state_e;
`else
    typedef enum logic [2:0] {StIdle, StAddr, StMem, StResp, StCfg} state_e;
`endif

    // Winner of IDLE arbitration, listed in priority order.
    typedef enum logic [1:0] {ArbNone, ArbCfg, ArbRead, ArbWrite} arb_sel_e;

    function automatic int unsigned delay_handle_width(input int unsigned n_handles);
        return (n_handles > 1) ? $clog2(n_handles) : 1;
    endfunction

    function automatic arb_sel_e arbitrate(input logic cfg, input logic rd, input logic wr);
        if (cfg) return ArbCfg;
        if (rd) return ArbRead;
        if (wr) return ArbWrite;
        return ArbNone;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port synchronous sample RAM with registered read; contents are never reset.
module delay_ram #(
    parameter int unsigned data_width = 16,
    parameter int unsigned mem_depth  = 4096,
    localparam int unsigned AW = $clog2(mem_depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [mem_depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line request controller: circular per-handle buffers in one shared sample RAM.
// Define DELAY_LINE_CLEAR_EN to zero a handle's region when it is reconfigured.
module delay_line_ctrl
    import delay_line_ctrl_pkg::*;
#(
    parameter int unsigned data_width = 16,
    parameter int unsigned n_handles  = 8,
    parameter int unsigned mem_depth  = 4096,
    localparam int unsigned AW = $clog2(mem_depth),
    localparam int unsigned HW = delay_handle_width(n_handles)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  delay_read_req,
    input  logic                  delay_write_req,
    input  logic [data_width-1:0] delay_req_handle,
    input  logic [data_width-1:0] delay_req_arg,
    output logic [data_width-1:0] delay_req_data,
    output logic                  delay_read_ready,
    output logic                  delay_write_ready,
    input  logic                  cfg_write,
    input  logic [HW-1:0]         cfg_handle,
    input  logic [AW-1:0]         cfg_base,
    input  logic [AW:0]           cfg_length,
    output logic                  cfg_ack,
    output logic                  busy
);

    localparam int unsigned LW = AW + 1;
    // Signed width wide enough for the tap argument and the buffer length plus a sign bit.
    localparam int unsigned CW = ((data_width > LW) ? data_width : LW) + 1;
    localparam logic [data_width-1:0] NHandles = data_width'(n_handles);

    state_e   state_q, state_d;
    arb_sel_e arb_sel;

    logic                  op_write_q;
    logic [data_width-1:0] handle_q, arg_q;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  valid_q, valid_d;

    logic [AW-1:0] base_q [n_handles];
    logic [AW:0]   len_q  [n_handles];
    logic [AW-1:0] wptr_q [n_handles];

    logic          pend_q;
    logic [HW-1:0] pend_handle_q;
    logic [AW-1:0] pend_base_q;
    logic [AW:0]   pend_len_q;

    logic [data_width-1:0] rdata_q;
    logic                  read_ready_q, write_ready_q, cfg_ack_q;

    logic accept, cfg_apply, read_done, write_done, cfg_done;

    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [data_width-1:0] ram_wdata, ram_rdata;

    logic [HW-1:0]        hidx;
    logic [AW-1:0]        cur_base, cur_wptr, wptr_next;
    logic [AW:0]          cur_len, wptr_inc;
    logic signed [CW-1:0] arg_s, len_s, wptr_s, tap_s, off_s;

`ifdef DELAY_LINE_CLEAR_EN
    logic [AW-1:0] clr_base_q;
    logic [AW:0]   clr_len_q, clr_cnt_q;
`endif

    assign hidx = handle_q[HW-1:0];

    // A ready pulse masks its own request so the core has one cycle to drop it.
    assign arb_sel = arbitrate(pend_q, delay_read_req && !read_ready_q,
                               delay_write_req && !write_ready_q);

    always_comb begin
        cur_base = base_q[hidx];
        cur_len  = len_q[hidx];
        cur_wptr = wptr_q[hidx];
        arg_s    = {{(CW - data_width){arg_q[data_width-1]}}, arg_q};
        len_s    = {{(CW - LW){1'b0}}, cur_len};
        wptr_s   = {{(CW - AW){1'b0}}, cur_wptr};
        if (arg_s < 0) begin
            tap_s = '0;
        end else if (arg_s >= len_s) begin
            tap_s = len_s - CW'(1);
        end else begin
            tap_s = arg_s;
        end
        off_s = wptr_s - CW'(1) - tap_s;
        if (off_s < 0) begin
            off_s = off_s + len_s;
        end
        valid_d   = (handle_q < NHandles) && (cur_len != '0);
        addr_d    = op_write_q ? (cur_base + cur_wptr) : (cur_base + off_s[AW-1:0]);
        wptr_inc  = {1'b0, cur_wptr} + LW'(1);
        wptr_next = (wptr_inc == cur_len) ? '0 : wptr_inc[AW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        cfg_apply  = 1'b0;
        read_done  = 1'b0;
        write_done = 1'b0;
        cfg_done   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = arg_q;
        unique case (state_q)
            StIdle: begin
                if (arb_sel == ArbCfg) begin
                    state_d = StCfg;
                end else if (arb_sel != ArbNone) begin
                    accept  = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: state_d = StMem;
            StMem: begin
                ram_we  = op_write_q && valid_q;
                state_d = StResp;
            end
            StResp: begin
                read_done  = !op_write_q;
                write_done = op_write_q;
                state_d    = StIdle;
            end
            StCfg: begin
                cfg_apply = 1'b1;
`ifdef DELAY_LINE_CLEAR_EN
                if (pend_len_q != '0) begin
                    state_d = StClear;
                end else begin
                    cfg_done = 1'b1;
                    state_d  = StIdle;
                end
`else
                cfg_done = 1'b1;
                state_d  = StIdle;
`endif
            end
`ifdef DELAY_LINE_CLEAR_EN
            StClear: begin
                ram_we    = 1'b1;
                ram_addr  = clr_base_q + clr_cnt_q[AW-1:0];
                ram_wdata = '0;
                if (clr_cnt_q == clr_len_q - LW'(1)) begin
                    cfg_done = 1'b1;
                    state_d  = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_write_q    <= 1'b0;
            handle_q      <= '0;
            arg_q         <= '0;
            addr_q        <= '0;
            valid_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_handle_q <= '0;
            pend_base_q   <= '0;
            pend_len_q    <= '0;
            rdata_q       <= '0;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            cfg_ack_q     <= 1'b0;
            for (int i = 0; i < n_handles; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                wptr_q[i] <= '0;
            end
`ifdef DELAY_LINE_CLEAR_EN
            clr_base_q <= '0;
            clr_len_q  <= '0;
            clr_cnt_q  <= '0;
`endif
        end else begin
            // A strobe arriving while CFG consumes the old one stays pending.
            if (cfg_write) begin
                pend_q        <= 1'b1;
                pend_handle_q <= cfg_handle;
                pend_base_q   <= cfg_base;
                pend_len_q    <= cfg_length;
            end else if (cfg_apply) begin
                pend_q <= 1'b0;
            end
            if (accept) begin
                op_write_q <= (arb_sel == ArbWrite);
                handle_q   <= delay_req_handle;
                arg_q      <= delay_req_arg;
            end
            if (state_q == StAddr) begin
                addr_q  <= addr_d;
                valid_q <= valid_d;
            end
            if (state_q == StMem && op_write_q && valid_q) begin
                wptr_q[hidx] <= wptr_next;
            end
            if (cfg_apply) begin
                base_q[pend_handle_q] <= pend_base_q;
                len_q[pend_handle_q]  <= pend_len_q;
                wptr_q[pend_handle_q] <= '0;
            end
            if (read_done) begin
                rdata_q <= valid_q ? ram_rdata : '0;
            end
            read_ready_q  <= read_done;
            write_ready_q <= write_done;
            cfg_ack_q     <= cfg_done;
`ifdef DELAY_LINE_CLEAR_EN
            if (cfg_apply) begin
                clr_base_q <= pend_base_q;
                clr_len_q  <= pend_len_q;
                clr_cnt_q  <= '0;
            end else if (state_q == StClear) begin
                clr_cnt_q <= clr_cnt_q + LW'(1);
            end
`endif
        end
    end

    delay_ram #(
        .data_width (data_width),
        .mem_depth  (mem_depth)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign delay_req_data    = rdata_q;
    assign delay_read_ready  = read_ready_q;
    assign delay_write_ready = write_ready_q;
    assign cfg_ack           = cfg_ack_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: drivers queue expected responses, a monitor checks
// every ready/ack pulse for data and cycle of arrival.
module tb_delay_line_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned HW = 3;
`ifdef DELAY_LINE_CLEAR_EN
    localparam int ClearEn = 1;
`else
    localparam int ClearEn = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          delay_read_req = 1'b0;
    logic          delay_write_req = 1'b0;
    logic [DW-1:0] delay_req_handle = '0;
    logic [DW-1:0] delay_req_arg = '0;
    logic [DW-1:0] delay_req_data;
    logic          delay_read_ready;
    logic          delay_write_ready;
    logic          cfg_write = 1'b0;
    logic [HW-1:0] cfg_handle = '0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW:0]   cfg_length = '0;
    logic          cfg_ack;
    logic          busy;

    rd_exp_t rd_q[$];
    int      wr_q[$];
    int      ack_q[$];
    rd_exp_t mon_e;
    int      mon_c;
    int      checks = 0;
    int      fails = 0;
    int      cyc = 0;

    delay_line_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .delay_read_req    (delay_read_req),
        .delay_write_req   (delay_write_req),
        .delay_req_handle  (delay_req_handle),
        .delay_req_arg     (delay_req_arg),
        .delay_req_data    (delay_req_data),
        .delay_read_ready  (delay_read_ready),
        .delay_write_ready (delay_write_ready),
        .cfg_write         (cfg_write),
        .cfg_handle        (cfg_handle),
        .cfg_base          (cfg_base),
        .cfg_length        (cfg_length),
        .cfg_ack           (cfg_ack),
        .busy              (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (delay_read_ready) begin
                checks++;
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("FAIL read_unexpected cyc=%0d data=%0d", cyc, delay_req_data);
                end else begin
                    mon_e = rd_q.pop_front();
                    if (delay_req_data !== mon_e.data || cyc != mon_e.cyc) begin
                        fails++;
                        $display("FAIL read_resp actual data=%0d cyc=%0d required data=%0d cyc=%0d",
                                 delay_req_data, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end
            if (delay_write_ready) begin
                checks++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected cyc=%0d", cyc);
                end else begin
                    mon_c = wr_q.pop_front();
                    if (cyc != mon_c) begin
                        fails++;
                        $display("FAIL write_latency actual cyc=%0d required cyc=%0d", cyc, mon_c);
                    end
                end
            end
            if (cfg_ack) begin
                checks++;
                if (ack_q.size() == 0) begin
                    fails++;
                    $display("FAIL ack_unexpected cyc=%0d", cyc);
                end else begin
                    mon_c = ack_q.pop_front();
                    if (cyc != mon_c) begin
                        fails++;
                        $display("FAIL cfg_ack_latency actual cyc=%0d required cyc=%0d", cyc, mon_c);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // which: 0 read ready, 1 write ready, 2 cfg ack
    task automatic wait_flag(input int which, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            case (which)
                0: seen = delay_read_ready;
                1: seen = delay_write_ready;
                default: seen = cfg_ack;
            endcase
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout actual=none required=pulse within 30 cycles", name);
        end
    endtask

    task automatic do_read(input logic [DW-1:0] h, input logic [DW-1:0] a,
                           input logic [DW-1:0] expd);
        @(negedge clk);
        delay_req_handle = h;
        delay_req_arg    = a;
        delay_read_req   = 1'b1;
        rd_q.push_back('{data: expd, cyc: cyc + 4});
        wait_flag(0, "read");
        delay_read_req = 1'b0;
    endtask

    task automatic do_write(input logic [DW-1:0] h, input logic [DW-1:0] v);
        @(negedge clk);
        delay_req_handle = h;
        delay_req_arg    = v;
        delay_write_req  = 1'b1;
        wr_q.push_back(cyc + 4);
        wait_flag(1, "write");
        delay_write_req = 1'b0;
    endtask

    task automatic do_cfg(input int h, input int base, input int len);
        @(negedge clk);
        cfg_handle = HW'(h);
        cfg_base   = AW'(base);
        cfg_length = (AW + 1)'(len);
        cfg_write  = 1'b1;
        ack_q.push_back(cyc + 3 + ClearEn * len);
        @(negedge clk);
        cfg_write = 1'b0;
        wait_flag(2, "cfg_ack");
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_busy", DW'(busy), 16'd0);
        check("reset_data", delay_req_data, 16'd0);
        check("reset_ready", DW'({delay_read_ready, delay_write_ready, cfg_ack}), 16'd0);

        // 1: disabled handle reads 0 with normal latency
        do_read(16'd0, 16'd0, 16'd0);

        // 2: fill handle 2 (base 100, length 4)
        do_cfg(2, 100, 4);
        do_write(16'd2, 16'd10);
        do_write(16'd2, 16'd20);
        do_write(16'd2, 16'd30);
        do_read(16'd2, 16'd0, 16'd30);
        do_read(16'd2, 16'd2, 16'd10);

        // 3: wrap, clamping, negative tap, invalid handles
        do_write(16'd2, 16'd40);
        do_write(16'd2, 16'd50);
        do_read(16'd2, 16'd0, 16'd50);
        do_read(16'd2, 16'd3, 16'd20);
        do_read(16'd2, 16'd9, 16'd20);
        do_read(16'd2, 16'hFFFB, 16'd50);
        do_write(16'd10, 16'd999);
        do_read(16'd2, 16'd0, 16'd50);
        do_read(16'd9, 16'd0, 16'd0);

        // 4: read and write together; shared arg 60 clamps the read tap to 3
        @(negedge clk);
        delay_req_handle = 16'd2;
        delay_req_arg    = 16'd60;
        delay_read_req   = 1'b1;
        delay_write_req  = 1'b1;
        rd_q.push_back('{data: 16'd20, cyc: cyc + 4});
        wr_q.push_back(cyc + 8);
        wait_flag(0, "pair_read");
        delay_read_req = 1'b0;
        wait_flag(1, "pair_write");
        delay_write_req = 1'b0;
        do_read(16'd2, 16'd0, 16'd60);

        // 5: config strobe while a read is in flight
        @(negedge clk);
        delay_req_handle = 16'd2;
        delay_req_arg    = 16'd1;
        delay_read_req   = 1'b1;
        rd_q.push_back('{data: 16'd50, cyc: cyc + 4});
        @(negedge clk);
        cfg_handle = 3'd2;
        cfg_base   = 12'd100;
        cfg_length = 13'd4;
        cfg_write  = 1'b1;
        ack_q.push_back(cyc + 5 + ClearEn * 4);
        @(negedge clk);
        cfg_write = 1'b0;
        wait_flag(0, "inflight_read");
        delay_read_req = 1'b0;
        wait_flag(2, "inflight_cfg_ack");
        do_read(16'd2, 16'd0, (ClearEn != 0) ? 16'd0 : 16'd40);
        do_write(16'd2, 16'd77);
        do_read(16'd2, 16'd0, 16'd77);

        // 6: asynchronous reset while a read sits in MEM
        @(negedge clk);
        delay_req_handle = 16'd2;
        delay_req_arg    = 16'd0;
        delay_read_req   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mem_busy", DW'(busy), 16'd1);
        reset_n = 1'b0;
        #1;
        check("async_data", delay_req_data, 16'd0);
        check("async_busy", DW'(busy), 16'd0);
        check("async_ready", DW'({delay_read_ready, delay_write_ready, cfg_ack}), 16'd0);
        delay_read_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_read(16'd2, 16'd0, 16'd0);

        repeat (5) @(negedge clk);
        check("read_queue_empty", DW'(rd_q.size()), 16'd0);
        check("write_queue_empty", DW'(wr_q.size()), 16'd0);
        check("ack_queue_empty", DW'(ack_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Services the DSP core's delay-request port (read/write request, handle, argument, ready).
- Manages up to n_handles circular delay buffers carved out of one shared on-chip sample RAM.
- Each handle has a host-configured base address and length, plus a private write pointer.
- Serialises core requests and host configuration writes onto the single RAM port.

Parameters:
data_width, 16, sample/handle/argument width
n_handles, 8, number of delay buffers
mem_depth, 4096, total RAM words (power of two); addr width AW = $clog2(mem_depth)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
delay_read_req  in  1  level; held by core until delay_read_ready
delay_write_req  in  1  level; held by core until delay_write_ready
delay_req_handle  in  data_width  buffer index (low bits used)
delay_req_arg  in  data_width  read: tap delay in samples (signed); write: sample value
delay_req_data  out  data_width  read result, valid with delay_read_ready
delay_read_ready  out  1  one-cycle pulse, read complete
delay_write_ready  out  1  one-cycle pulse, write complete
cfg_write  in  1  one-cycle config strobe from host command path
cfg_handle  in  $clog2(n_handles)  handle to configure
cfg_base  in  AW  buffer base address
cfg_length  in  AW+1  buffer length in words; 0 disables the handle
cfg_ack  out  1  one-cycle pulse, config applied
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; every handle's base, length and wptr cleared to 0 (all handles disabled). RAM contents are not reset.
- Per-handle table, held in registers: base[AW], length[AW+1], wptr[AW].
- States: IDLE, ADDR, MEM, RESP, CFG. CLEAR exists only with the optional feature.
- IDLE arbitration, fixed priority: pending cfg > read > write.
  - cfg_write is captured into a pending latch (handle, base, length) in any state. A second strobe while one is pending overwrites it.
  - Only IDLE accepts; the request's handle and arg are latched into internal registers.
- Handle invalid: index >= n_handles or length == 0.
  - Read: delay_req_data = 0.
  - Write: discarded; no pointer change.
  - Ready still pulses with the same latency as a valid request.
- ADDR cycle, read:
  - d = clamp(arg, 0, length-1); negative arg gives 0.
  - off = wptr - 1 - d; add length if negative.
  - addr = base + off, truncated to AW bits. base+length overflowing mem_depth wraps; this is a host config error and is not checked.
- ADDR cycle, write: addr = base + wptr.
- MEM cycle: RAM access (synchronous, 1-cycle read).
  - A write also updates wptr: wptr+1, reset to 0 when wptr+1 == length.
- RESP cycle: the matching ready pulses for exactly one cycle. Read data is registered onto delay_req_data and held until the next read completes. Return to IDLE.
- Latency: ready asserts 3 cycles after the accept edge.
- A request still high in the cycle after its ready pulse is treated as a new request; the core must drop req on seeing ready.
- Read and write asserted together: read served first, write on the next IDLE visit.
- CFG state: writes base and length, sets wptr = 0, pulses cfg_ack, returns to IDLE. Config is never applied mid-request.
- Reconfiguring a handle also discards its history: the read offset restarts from wptr = 0.

Optional Feature:
- Macro: DELAY_LINE_CLEAR_EN.
- Defined: CFG enters CLEAR, writing 0 to addresses base..base+length-1, one word per cycle.
  - busy stays high; core requests wait.
  - cfg_ack pulses after the last word.
  - length == 0 skips CLEAR.
  - Reset during CLEAR aborts it; the region stays partially cleared.
- Undefined: no CLEAR state; cfg_ack pulses 1 cycle after CFG entry; buffer holds stale data.

Decomposition:
- Shared package/header delay_line.vh: state encodings, DELAY_HANDLE_WIDTH, and the arbitration priority constants.
- One sub-module, delay_ram: single-port synchronous RAM of mem_depth x data_width with write-enable and registered read. It must infer block RAM.
- The address/wrap arithmetic stays inline in delay_line_ctrl.

Test Plan:
1. Reset then read handle 0 -> delay_read_ready pulses 3 cycles after accept; delay_req_data = 0 (disabled handle).
2. cfg handle 2 (base 100, length 4), then writes 10, 20, 30 -> read arg 0 returns 30, arg 2 returns 10; wptr = 3.
3. Continue writes 40, 50 on handle 2 (wrap) -> read arg 0 = 50 at RAM addr 100; arg 3 = 20; arg 9 clamps to 3 and returns 20; arg -5 returns 50.
4. Read and write to handle 2 raised together -> read_ready pulses first, write_ready 4 cycles later; read data reflects state before the write.
5. cfg_write strobed during a read in flight -> read completes unaffected, then cfg_ack; with DELAY_LINE_CLEAR_EN and length 4, cfg_ack arrives after 4 clear cycles and a read then returns 0.
6. Assert reset_n low mid-MEM -> all outputs 0 immediately (async); afterwards handle 2 reads as disabled (returns 0).
